// File: rtl/frequency_counter_bcd.sv
// Gated edge counter with a sequential double-dabble converter that publishes packed BCD.
// Counting never pauses: the converter works on the previous window while the next one runs.
module frequency_counter_bcd #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned COUNT_BITS    = 14,
    parameter int unsigned PERIOD_BITS   = 16,
    parameter int unsigned UPDATE_PERIOD = 11999
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   signal,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic                   period_load,
    input  logic                   mode_both_edges,
    input  logic                   hold,
    output logic [4*DIGITS-1:0]    bcd_out,
    output logic                   overflow,
    output logic                   valid,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    // Scratch must hold 2^COUNT_BITS-1 in BCD and always has at least one nibble above DIGITS.
    localparam int unsigned SCR_NEED   = (COUNT_BITS + 2) / 3;
    localparam int unsigned SCR_DIGITS = (SCR_NEED > DIGITS) ? SCR_NEED : DIGITS + 1;
    localparam int unsigned SW         = 4 * SCR_DIGITS;
    localparam int unsigned BW         = 4 * DIGITS;
    localparam int unsigned BIT_W      = $clog2(COUNT_BITS);

    localparam logic [PERIOD_BITS-1:0] MIN_PERIOD = PERIOD_BITS'(COUNT_BITS + 1);
    localparam logic [COUNT_BITS-1:0]  CNT_MAX    = {COUNT_BITS{1'b1}};
    localparam logic [BIT_W-1:0]       LAST_BIT   = BIT_W'(COUNT_BITS - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StConvert = 2'd1,
        StPublish = 2'd2
    } state_e;

    logic                   r_s1, r_s2, r_s3;
    logic [PERIOD_BITS-1:0] r_period;
    logic [PERIOD_BITS-1:0] r_clk_cnt;
    logic [COUNT_BITS-1:0]  r_edge_cnt;
    state_e                 r_state;
    logic [COUNT_BITS-1:0]  r_shift;
    logic [SW-1:0]          r_scr;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic [BW-1:0]          r_bcd;
    logic                   r_overflow;
    logic                   r_valid;

    logic                   w_edge;
    logic                   w_terminal;
    logic                   w_capture;
    logic [COUNT_BITS-1:0]  w_edge_next;
    logic [PERIOD_BITS-1:0] w_period_clamped;
    logic [SW-1:0]          w_adj;

    assign w_edge     = mode_both_edges ? (r_s2 ^ r_s3) : (r_s2 & ~r_s3);
    assign w_terminal = (r_clk_cnt >= r_period);
    // A simultaneous period_load discards the window instead of capturing it.
    assign w_capture  = w_terminal & ~period_load;

    assign w_edge_next = (w_edge && (r_edge_cnt != CNT_MAX)) ? r_edge_cnt + 1'b1 : r_edge_cnt;

    assign w_period_clamped = (period < MIN_PERIOD) ? MIN_PERIOD : period;

    always_comb begin
        w_adj = r_scr;
        for (int i = 0; i < int'(SCR_DIGITS); i++) begin
            if (r_scr[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_period   <= PERIOD_BITS'(UPDATE_PERIOD);
            r_clk_cnt  <= '0;
            r_edge_cnt <= '0;
        end else begin
            r_s1 <= signal;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (period_load) begin
                r_period   <= w_period_clamped;
                r_clk_cnt  <= '0;
                r_edge_cnt <= '0;
            end else if (w_terminal) begin
                r_clk_cnt  <= '0;
                r_edge_cnt <= '0;
            end else begin
                r_clk_cnt  <= r_clk_cnt + 1'b1;
                r_edge_cnt <= w_edge_next;
            end
        end
    end

    // The period clamp guarantees the FSM is back in StIdle before the next capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_scr      <= '0;
            r_bit_cnt  <= '0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_capture) begin
                        r_shift   <= w_edge_next;
                        r_scr     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= StConvert;
                    end
                end
                StConvert: begin
                    r_scr     <= SW'({w_adj, r_shift[COUNT_BITS-1]});
                    r_shift   <= {r_shift[COUNT_BITS-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        r_state <= StPublish;
                    end
                end
                StPublish: begin
                    if (!hold) begin
                        r_valid <= 1'b1;
                        if (|r_scr[SW-1:BW]) begin
                            r_overflow <= 1'b1;
                            r_bcd      <= {DIGITS{4'h9}};
                        end else begin
                            r_overflow <= 1'b0;
                            r_bcd      <= r_scr[BW-1:0];
                        end
                    end
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bcd_out   = r_bcd;
    assign overflow  = r_overflow;
    assign valid     = r_valid;
    assign busy      = (r_state == StConvert) || (r_state == StPublish);
    assign dbg_state = r_state;

endmodule

// File: doc/frequency_counter_bcd.md
Name: frequency_counter_bcd

Overview:
Next-generation frequency counter. It counts leading edges (or both edges) of an asynchronous input over a programmable gate window and converts the count to DIGITS packed BCD digits. Counting has no dead time: the gate counter keeps running while a sequential double-dabble converter processes the previous window. The output feeds a multi-digit display driver or a register read-back path.

Parameters:
DIGITS, 4, number of BCD output digits
COUNT_BITS, 14, edge counter width; must satisfy 2^COUNT_BITS > 10^DIGITS-1
PERIOD_BITS, 16, gate period register width
UPDATE_PERIOD, 11999, reset value of gate period; window length = period+1 clk cycles

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted), released synchronously externally
signal  in  1  asynchronous measured input
period  in  PERIOD_BITS  new gate period value
period_load  in  1  load period, restart window
mode_both_edges  in  1  0 = count rising edges, 1 = count rising and falling edges
hold  in  1  1 = freeze displayed result
bcd_out  out  4*DIGITS  packed BCD result, digit 0 (units) in [3:0]
overflow  out  1  last published window exceeded 10^DIGITS-1
valid  out  1  one-cycle strobe when bcd_out/overflow update
busy  out  1  converter active
dbg_state  out  2  converter state

Behaviour:
- Reset (asynchronous, reset=0): all flops cleared; period register = UPDATE_PERIOD; bcd_out=0, overflow=0, valid=0, busy=0, state=IDLE.
- Edge detect: signal passes through a 2-flop synchroniser (s1,s2), then s3 <= s2. rise = s2 & ~s3; both = s2 ^ s3. Selected edge = rise or both, chosen by mode_both_edges, which is sampled every cycle. Latency from signal transition to counted edge = 3 clk.
- Gate counter clk_cnt increments every cycle. At the terminal cycle (clk_cnt >= period_reg):
  - clk_cnt <= 0.
  - The captured count is edge_cnt, plus 1 if an edge is detected in the terminal cycle, saturated. This value goes to the converter.
  - edge_cnt <= 0.
- edge_cnt saturates at 2^COUNT_BITS-1 and never wraps.
- period_load: period_reg <= max(period, COUNT_BITS+1). Clamping guarantees a conversion finishes before the next window closes.
  - In the same cycle, clk_cnt and edge_cnt are cleared and the partial window is discarded.
  - A conversion already in progress completes normally.
  - If period_load coincides with a terminal cycle, period_load wins: no capture occurs.
- Converter state machine:
  - IDLE (0): wait for a capture.
  - CONVERT (1): double-dabble over COUNT_BITS cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left one bit, bringing in the count MSB. BCD scratch width is 4*DIGITS plus enough headroom to hold up to 2^COUNT_BITS-1 without loss.
  - PUBLISH (2): one cycle, then back to IDLE.
  - State 3 is illegal and returns to IDLE.
- busy=1 in CONVERT and PUBLISH.
- Publish step, when hold=0:
  - If count > 10^DIGITS-1: overflow <= 1 and bcd_out <= all nibbles 9.
  - Otherwise: overflow <= 0 and bcd_out <= the low DIGITS nibbles.
  - valid is pulsed for 1 cycle.
- Publish step, when hold=1: bcd_out and overflow are unchanged, valid stays 0, and the result is dropped.
- Latency: terminal cycle T, CONVERT in T+1..T+COUNT_BITS, PUBLISH at T+COUNT_BITS+1. bcd_out and valid are registered and visible from T+COUNT_BITS+2.
- Windows publish back-to-back with period_reg+1 cycles spacing. Edges in every cycle are counted; there is no dead time.

Test Plan:
- Reset mid-conversion: assert reset=0 while busy=1 → bcd_out=0, overflow=0, valid=0, state=IDLE immediately (asynchronous). First valid appears only after a full new window.
- Defaults (DIGITS=4, COUNT_BITS=14). period_load with period=99, square wave of period 4 clk, mode_both_edges=0 → every 100 clk, valid pulses with bcd_out=16'h0025, overflow=0. With mode_both_edges=1 → bcd_out=16'h0050.
- DIGITS=2, COUNT_BITS=7:
  - period=99, signal toggling every clk, both edges → 100 edges → overflow=1, bcd_out=8'h99.
  - period=199, same stimulus → edge_cnt saturates at 127 → overflow=1, bcd_out=8'h99.
  - period=98, same stimulus → count 99 → bcd_out=8'h99, overflow=0.
- Clamp: period_load with period=3 (COUNT_BITS=14) → period_reg=15. Results publish every 16 clk with no missed conversion; busy never overlaps the next capture.
- hold=1 across two windows with changing input frequency → bcd_out frozen, no valid pulses. After hold=0, the next window publishes the new value.
- period_load asserted in a terminal cycle → no capture, no valid for that window. A new window starts with the new period and publishes after period_reg+1+COUNT_BITS+2 clk.
